// File: rtl/multicycle_control.sv
// Multicycle RV32I main control FSM: sequences fetch/decode/execute/mem/writeback over a
// shared memory port, with bounded mem_ready waits and a sticky, absorbing fault state.
module multicycle_control #(
  parameter int MAX_WAIT   = 15,
  parameter int WAIT_W     = 8,
  parameter int EN_JAL_LUI = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       fault,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11,
    S_FAULT    = 4'd15
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);

  state_t            state;
  state_t            state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_state;
  logic              timeout;

  assign mem_state = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  // A completing handshake in the last allowed cycle beats the timeout.
  assign timeout   = mem_state && !mem_ready && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:    if (mem_ready) state_nxt = S_DECODE;
                  else if (timeout) state_nxt = S_FAULT;
      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_nxt = S_MEMADR;
          OP_RTYPE:          state_nxt = S_EXECR;
          OP_ITYPE:          state_nxt = S_EXECI;
          OP_BRANCH:         state_nxt = S_BEQ;
          OP_JAL:            state_nxt = (EN_JAL_LUI != 0) ? S_JAL : S_FAULT;
          OP_LUI:            state_nxt = (EN_JAL_LUI != 0) ? S_LUI : S_FAULT;
          default:           state_nxt = S_FAULT;
        endcase
      end
      S_MEMADR:   state_nxt = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_nxt = S_MEMWB;
                  else if (timeout) state_nxt = S_FAULT;
      S_MEMWB:    state_nxt = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_nxt = S_FETCH;
                  else if (timeout) state_nxt = S_FAULT;
      S_EXECR:    state_nxt = S_ALUWB;
      S_EXECI:    state_nxt = S_ALUWB;
      S_ALUWB:    state_nxt = S_FETCH;
      S_BEQ:      state_nxt = S_FETCH;
      S_JAL:      state_nxt = S_ALUWB;
      S_LUI:      state_nxt = S_FETCH;
      default:    state_nxt = S_FAULT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (!mem_state || mem_ready || (state_nxt != state))
        wait_cnt <= '0;
      else if (wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + WAIT_W'(1);
    end
  end

  // Outputs are gated by rst_n so an in-flight strobe drops the moment reset asserts.
  always_comb begin
    pc_write   = 1'b0;
    adr_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    result_src = 2'b00;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    fault      = 1'b0;
    state_dbg  = 4'd0;
    if (rst_n) begin
      state_dbg = state;
      case (state)
        S_FETCH: begin
          mem_read   = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        S_DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
        end
        S_MEMADR: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
        end
        S_MEMREAD: begin
          mem_read = 1'b1;
          adr_src  = 1'b1;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          result_src = 2'b01;
        end
        S_MEMWRITE: begin
          mem_write = 1'b1;
          adr_src   = 1'b1;
        end
        S_EXECR: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b10;
        end
        S_EXECI: begin
          alu_src_a = 2'b10;
          alu_src_b = 2'b01;
          alu_op    = 2'b11;
        end
        S_ALUWB:  reg_write = 1'b1;
        S_BEQ: begin
          alu_src_a = 2'b10;
          alu_op    = 2'b01;
          pc_write  = zero;
        end
        S_JAL: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b10;
          pc_write  = 1'b1;
        end
        S_LUI: begin
          reg_write  = 1'b1;
          result_src = 2'b11;
        end
        S_FAULT:  fault = 1'b1;
        default:  fault = 1'b1;
      endcase
    end
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
Multicycle RV32I main control unit. It is the FSM successor to the single-cycle main decoder, and it sequences fetch, decode, execute, memory and writeback over several cycles on a shared instruction/data memory. It adds three things to the single-cycle decoder:
- variable-latency memory handshake (mem_ready);
- a bounded wait timeout;
- jal/lui support and sticky fault reporting.

It sits between the datapath (IR, PC, ALU, register file) and the unified memory port.

Parameters:
MAX_WAIT, 15, max consecutive cycles a memory state waits for mem_ready before faulting (1..255).
WAIT_W, 8, width of the wait counter; must satisfy 2**WAIT_W > MAX_WAIT.
EN_JAL_LUI, 1, 1 = decode jal (1101111) and lui (0110111); 0 = treat them as illegal.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
opcode  in  7  instruction[6:0] from IR; sampled in DECODE only.
zero  in  1  ALU zero flag.
mem_ready  in  1  memory completes the current read/write this cycle.
pc_write  out  1  PC load enable.
adr_src  out  1  0 = memory address from PC, 1 = from ALU result register.
mem_read  out  1  memory read request.
mem_write  out  1  memory write request.
ir_write  out  1  IR and old-PC load enable.
reg_write  out  1  register file write enable.
result_src  out  2  00 ALUOut, 01 memory data, 10 ALU result direct, 11 immediate (lui).
alu_src_a  out  2  00 PC, 01 old PC, 10 rs1.
alu_src_b  out  2  00 rs2, 01 immediate, 10 constant 4.
alu_op  out  2  00 add, 01 sub/branch, 10 R-type funct decode, 11 I-type funct decode.
fault  out  1  sticky: illegal opcode or memory timeout.
state_dbg  out  4  current state encoding.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10, LUI=11, FAULT=15.
- The state register and wait counter are the only flops. Outputs are combinational from state (Moore), except the gating by mem_ready and zero noted below.
- Reset: while rst_n=0, state=FETCH and wait_cnt=0. All outputs are forced to 0, including mem_read, all strobes and fault. Reset may be asserted in any state; it aborts the current instruction with no partial write strobe.
- Unlisted outputs are 0 in every state.
- FETCH: mem_read=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write=pc_write=mem_ready. Go to DECODE on mem_ready, else stay.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL (if EN_JAL_LUI)
  - 0110111 -> LUI (if EN_JAL_LUI)
  - else -> FAULT
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Go to MEMREAD if opcode=0000011, else MEMWRITE.
- MEMREAD: mem_read=1, adr_src=1. Go to MEMWB on mem_ready.
- MEMWB: reg_write=1, result_src=01. Go to FETCH.
- MEMWRITE: mem_write=1, adr_src=1. Go to FETCH on mem_ready.
- EXECR: alu_src_a=10, alu_src_b=00, alu_op=10. Go to ALUWB.
- EXECI: alu_src_a=10, alu_src_b=01, alu_op=11. Go to ALUWB.
- ALUWB: reg_write=1, result_src=00. Go to FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00. pc_write=zero. Go to FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_write=1. Go to ALUWB (rd = old PC + 4).
- LUI: reg_write=1, result_src=11. Go to FETCH.
- Wait counter:
  - In FETCH, MEMREAD or MEMWRITE with mem_ready=0, wait_cnt increments, saturating at MAX_WAIT.
  - It clears on any state change or when mem_ready=1.
  - If mem_ready=0 while wait_cnt=MAX_WAIT-1, the next state is FAULT (stall cycles never exceed MAX_WAIT).
  - mem_ready arriving in that same cycle wins over the timeout.
- FAULT: absorbing. fault=1 and every strobe is 0. Exit only via rst_n.
- Pipelined mem_ready (asserted in the same cycle as the request) gives zero stall cycles.
- CPI with mem_ready=1: lw 5, sw 4, R/I 4, beq 3, jal 4, lui 3.

Test Plan:
1. R-type: opcode=0110011, mem_ready=1. States 0,1,6,8,0. reg_write=1 only in cycle 4; pc_write=1 only in cycle 1.
2. lw with memory stalls: opcode=0000011, mem_ready low for 3 cycles in FETCH and 2 in MEMREAD. 10 cycles total; ir_write pulses once; reg_write with result_src=01 in the final cycle.
3. beq: opcode=1100011, zero=1 then zero=0 on a repeat. pc_write=1 in BEQ for the first run, 0 for the second; mem_write and reg_write stay 0 throughout.
4. Timeout: MAX_WAIT=15, opcode=0100011, mem_ready held 0 in MEMWRITE. Enters FAULT after exactly 15 stall cycles; fault=1 and mem_write=0 thereafter until rst_n=0.
5. Illegal/gated opcodes: opcode=1111111 -> FAULT from DECODE. With EN_JAL_LUI=0, opcode=1101111 -> FAULT. With EN_JAL_LUI=1, jal gives states 0,1,10,8,0 with pc_write=1 in JAL.
6. Reset mid-MEMWRITE: pull rst_n low while mem_write=1. All outputs go to 0 immediately (async). After release, state_dbg=0 and mem_read=1 on the next cycle.
